// File: rtl/code_entry_if.sv
// code_entry_if: valid/ready handshake carrying a finished DIGITS-long code
// from the entry front end (master) to the comparator (slave).
interface code_entry_if #(
  parameter int DIGITS = 4,
  parameter int DW     = 4
);
  logic [DIGITS*DW-1:0] code;
  logic                 code_valid;
  logic                 code_ready;

  modport master (
    output code,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  code,
    input  code_valid,
    output code_ready
  );
endinterface

// File: rtl/code_entry.sv
// code_entry: digit-entry front end for the lock datapath.
// Builds a DIGITS-long code from up/down/cnf/back/clr pulses, drives a
// per-slot display bus and offers the finished code over a valid/ready
// handshake. Event priority per cycle: clr > back > cnf > up > down.
// Optional feature: define CODE_ENTRY_MASK_EN to show confirmed digits as
// MASK (BLANK-1) on the display; the code itself is never masked.
module code_entry #(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10,
  parameter int DW     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         up,
  input  logic                         down,
  input  logic                         cnf,
  input  logic                         back,
  input  logic                         clr,
  code_entry_if.master                 cbus,
  output logic [DIGITS*DW-1:0]         disp,
  output logic [$clog2(DIGITS+1)-1:0]  count
);

  localparam int             CW    = $clog2(DIGITS+1);
  localparam logic [DW-1:0]  BLANK = {DW{1'b1}};
  localparam logic [DW-1:0]  MASK  = {{(DW-1){1'b1}}, 1'b0};
  localparam logic [DW-1:0]  TOP   = DW'(RADIX-1);
  localparam logic [CW-1:0]  LAST  = CW'(DIGITS-1);
  localparam logic [CW-1:0]  FULL  = CW'(DIGITS);
  localparam logic [DIGITS*DW-1:0] DISP_RST = {{(DIGITS-1){BLANK}}, {DW{1'b0}}};

`ifdef CODE_ENTRY_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  typedef enum logic {
    ST_ENTRY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        cur_q, cur_d;
  logic [CW-1:0]        count_q, count_d;
  // dig_q[i] is the i-th confirmed digit in entry order (0 = first).
  logic [DW-1:0]        dig_q [0:DIGITS-2];
  logic [DW-1:0]        dig_d [0:DIGITS-2];
  logic [DIGITS*DW-1:0] code_q, code_d;
  logic                 valid_q, valid_d;
  logic [DIGITS*DW-1:0] disp_q, disp_d;

  // Next-state logic: one event per cycle in ENTRY, accept/abort in HOLD.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    count_d = count_q;
    dig_d   = dig_q;
    code_d  = code_q;
    valid_d = valid_q;
    case (state_q)
      ST_ENTRY: begin
        if (clr) begin
          count_d = '0;
          cur_d   = '0;
          for (int i = 0; i < DIGITS-1; i++) begin
            dig_d[i] = '0;
          end
        end else if (back) begin
          cur_d = '0;
          if (count_q != '0) begin
            count_d = count_q - CW'(1);
          end else begin
            count_d = count_q;
          end
        end else if (cnf) begin
          cur_d = '0;
          if (count_q < LAST) begin
            for (int i = 0; i < DIGITS-1; i++) begin
              if (count_q == CW'(i)) begin
                dig_d[i] = cur_q;
              end else begin
                dig_d[i] = dig_q[i];
              end
            end
            count_d = count_q + CW'(1);
          end else begin
            // Last digit: first-entered digit lands in the MS slot of code.
            for (int i = 0; i < DIGITS-1; i++) begin
              code_d[(DIGITS-1-i)*DW +: DW] = dig_q[i];
            end
            code_d[DW-1:0] = cur_q;
            valid_d = 1'b1;
            state_d = ST_HOLD;
            count_d = FULL;
          end
        end else if (up) begin
          if (cur_q == TOP) begin
            cur_d = '0;
          end else begin
            cur_d = cur_q + DW'(1);
          end
        end else if (down) begin
          if (cur_q == '0) begin
            cur_d = TOP;
          end else begin
            cur_d = cur_q - DW'(1);
          end
        end else begin
          cur_d = cur_q;
        end
      end
      ST_HOLD: begin
        // Accept and abort both return to a fresh entry; code keeps its value.
        if (clr || cbus.code_ready) begin
          state_d = ST_ENTRY;
          valid_d = 1'b0;
          count_d = '0;
          cur_d   = '0;
          for (int i = 0; i < DIGITS-1; i++) begin
            dig_d[i] = '0;
          end
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        state_d = ST_ENTRY;
        valid_d = 1'b0;
        count_d = '0;
        cur_d   = '0;
      end
    endcase
  end

  // Display image built from next-state values so disp is registered in step.
  always_comb begin
    logic [DW-1:0] sel;
    logic          hit;
    disp_d = {DIGITS{BLANK}};
    sel    = '0;
    hit    = 1'b0;
    if (state_d == ST_HOLD) begin
      // In HOLD the newest digit sits in slot 0, which is exactly code order.
      if (MASK_EN) begin
        disp_d = {DIGITS{MASK}};
      end else begin
        disp_d = code_d;
      end
    end else begin
      disp_d[DW-1:0] = cur_d;
      // Slot k (1..count) shows digit index count-k: newest in slot 1.
      for (int k = 1; k < DIGITS; k++) begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < DIGITS-1; i++) begin
          sel = sel | ({DW{32'(count_d) == k + i}} & dig_d[i]);
          hit = hit | (32'(count_d) == k + i);
        end
        if (!hit) begin
          disp_d[k*DW +: DW] = BLANK;
        end else if (MASK_EN) begin
          disp_d[k*DW +: DW] = MASK;
        end else begin
          disp_d[k*DW +: DW] = sel;
        end
      end
    end
  end

  // State and output registers; rst drops everything including a pending code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ENTRY;
      cur_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DIGITS-1; i++) begin
        dig_q[i] <= '0;
      end
      code_q  <= '0;
      valid_q <= 1'b0;
      disp_q  <= DISP_RST;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      count_q <= count_d;
      for (int i = 0; i < DIGITS-1; i++) begin
        dig_q[i] <= dig_d[i];
      end
      code_q  <= code_d;
      valid_q <= valid_d;
      disp_q  <= disp_d;
    end
  end

  assign disp            = disp_q;
  assign count           = count_q;
  assign cbus.code       = code_q;
  assign cbus.code_valid = valid_q;

endmodule

// File: tb/tb_code_entry.sv
// tb_code_entry: directed bench for code_entry (DIGITS=4, RADIX=10, DW=4).
// Expected codes go into a scoreboard queue at stimulus time; a monitor pops
// and compares at every valid/ready handshake. Display expectations follow
// CODE_ENTRY_MASK_EN when the bench is built with it.
module tb_code_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, cnf, back, clr;
  logic [15:0] disp;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] dropped;

`ifdef CODE_ENTRY_MASK_EN
  localparam bit M = 1'b1;
`else
  localparam bit M = 1'b0;
`endif

  code_entry_if #(.DIGITS(4), .DW(4)) cbus ();

  code_entry #(.DIGITS(4), .RADIX(10), .DW(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .up    (up),
    .down  (down),
    .cnf   (cnf),
    .back  (back),
    .clr   (clr),
    .cbus  (cbus),
    .disp  (disp),
    .count (count)
  );

  always #5 clk = ~clk;

  // Pick the hand-computed display value for the current build.
  function automatic logic [15:0] dv(input logic [15:0] plain, input logic [15:0] masked);
    return M ? masked : plain;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle of pulses (inputs change only at posedge+1).
  task automatic step(input logic u, input logic d, input logic c,
                      input logic b, input logic cl, input logic r);
    up = u; down = d; cnf = c; back = b; clr = cl; cbus.code_ready = r;
    @(posedge clk); #1;
    up = 1'b0; down = 1'b0; cnf = 1'b0; back = 1'b0; clr = 1'b0;
    cbus.code_ready = 1'b0;
  endtask

  task automatic ups(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter(input int v);
    ups(v);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Handshake monitor: sampled mid-cycle, transfer completes at next posedge.
  always @(negedge clk) begin
    if (!rst && cbus.code_valid && cbus.code_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake actual=%h required=none", cbus.code);
      end else begin
        chk("handshake_code", {16'h0, cbus.code}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1;
    up = 1'b0; down = 1'b0; cnf = 1'b0; back = 1'b0; clr = 1'b0;
    cbus.code_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", cbus.code_valid, 1'b0);
    chk("rst_code", cbus.code, 16'h0000);
    chk("rst_count", count, 3'd0);
    chk("rst_disp", disp, 16'hFFF0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // 3x up, 1x down
    ups(3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("updown_disp", disp, 16'hFFF2);
    chk("updown_count", count, 3'd0);
    // code_ready without a pending code does nothing
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_ready_disp", disp, 16'hFFF2);
    chk("idle_ready_valid", cbus.code_valid, 1'b0);

    // wrap both ways
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_disp", disp, 16'hFFF0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_down", disp, 16'hFFF9);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_up", disp, 16'hFFF0);

    // enter 1,2,3,4
    enter(1);
    chk("d1_disp", disp, dv(16'hFF10, 16'hFFE0));
    chk("d1_count", count, 3'd1);
    enter(2);
    chk("d2_disp", disp, dv(16'hF120, 16'hFEE0));
    enter(3);
    chk("d3_disp", disp, dv(16'h1230, 16'hEEE0));
    chk("d3_count", count, 3'd3);
    ups(4);
    exp_q.push_back(16'h1234);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("final_valid", cbus.code_valid, 1'b1);
    chk("final_code", cbus.code, 16'h1234);
    chk("final_count", count, 3'd4);
    chk("hold_disp", disp, dv(16'h1234, 16'hEEEE));

    // HOLD for 5 cycles, up/down ignored
    for (int i = 0; i < 5; i++) begin
      step(i[0] == 1'b0, i[0] == 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold_code", cbus.code, 16'h1234);
      chk("hold_valid", cbus.code_valid, 1'b1);
    end
    chk("hold_disp_after", disp, dv(16'h1234, 16'hEEEE));

    // accept, with an up in the same cycle that must be dropped
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("accept_valid", cbus.code_valid, 1'b0);
    chk("accept_count", count, 3'd0);
    chk("accept_disp", disp, 16'hFFF0);
    chk("accept_code_kept", cbus.code, 16'h1234);

    // 5,6 then back x3
    enter(5);
    enter(6);
    chk("d56_disp", disp, dv(16'hF560, 16'hFEE0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("back1_count", count, 3'd1);
    chk("back1_disp", disp, dv(16'hFF50, 16'hFFE0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("back3_count", count, 3'd0);
    chk("back3_disp", disp, 16'hFFF0);

    // cnf+up with cur=3: cnf wins
    ups(3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("cnf_up_count", count, 3'd1);
    chk("cnf_up_disp", disp, dv(16'hFF30, 16'hFFE0));
    // clr+back: full clear
    ups(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr_back_count", count, 3'd0);
    chk("clr_back_disp", disp, 16'hFFF0);

    // clr in HOLD discards the code without a handshake
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero_valid", cbus.code_valid, 1'b1);
    chk("zero_code", cbus.code, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hold_clr_valid", cbus.code_valid, 1'b0);
    chk("hold_clr_disp", disp, 16'hFFF0);

    // 7,8 then finish 7821, rst while in HOLD
    enter(7);
    enter(8);
    chk("d78_disp", disp, dv(16'hF780, 16'hFEE0));
    ups(2);
    chk("d78_cur_disp", disp, dv(16'hF782, 16'hFEE2));
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("d782_disp", disp, dv(16'h7820, 16'hEEE0));
    ups(1);
    exp_q.push_back(16'h7821);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("c7821_valid", cbus.code_valid, 1'b1);
    chk("c7821_code", cbus.code, 16'h7821);
    chk("c7821_disp", disp, dv(16'h7821, 16'hEEEE));
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", cbus.code_valid, 1'b0);
    chk("async_rst_code", cbus.code, 16'h0000);
    chk("async_rst_count", count, 3'd0);
    chk("async_rst_disp", disp, 16'hFFF0);
    dropped = exp_q.pop_back();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", cbus.code_valid, 1'b0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_entry.md
# code_entry

Parametrised digit-entry front end for the lock datapath. Builds a DIGITS-long code one digit at a time from single-cycle up/down/confirm/back/clear pulses and drives a per-slot display bus. It hands the finished code to the comparator over a valid/ready handshake. It sits between the debounced key pulses and the compare/state logic.

## Interface
Parameters:
- DIGITS, 4, code length in digits (≥2)
- RADIX, 10, digit values 0..RADIX-1 (RADIX ≤ 2^DW−2)
- DW, 4, bits per digit/display slot

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- up  in  1  pulse: increment current digit
- down  in  1  pulse: decrement current digit
- cnf  in  1  pulse: confirm current digit
- back  in  1  pulse: delete last confirmed digit
- clr  in  1  pulse: abort entry, clear everything
- code_ready  in  1  consumer accepts code
- disp  out  DIGITS*DW  display slots; slot k = disp[k*DW +: DW]
- count  out  $clog2(DIGITS+1)  confirmed digits
- code  out  DIGITS*DW  finished code; digit 0 (first entered) in the MS slot
- code_valid  out  1  code available

## Operation
- Constants: BLANK = all ones (DW bits); MASK = BLANK−1.
- State machine:
  - ENTRY: editing.
  - HOLD: code_valid=1, waiting for code_ready.
- Internal registers:
  - cur: current digit, 0..RADIX-1.
  - buf: confirmed digits.
- Event priority per cycle: clr > back > cnf > up > down. Exactly one event acts per cycle; lower-priority events that cycle are dropped.
- ENTRY:
  - up: cur = cur+1; RADIX-1 wraps to 0.
  - down: cur = cur−1; 0 wraps to RADIX-1.
  - cnf with count < DIGITS-1: append cur to buf; count+1; cur=0.
  - cnf with count = DIGITS-1: code = {buf, cur}; code_valid=1; go to HOLD; count=DIGITS.
  - back with count=0: cur=0 only.
  - back with count>0: drop newest digit; count−1; cur=0.
  - clr: count=0; cur=0; buf cleared.
- HOLD:
  - up, down, cnf and back are ignored.
  - code_ready=1 at a clk edge: code_valid=0; count=0; cur=0; go to ENTRY. code keeps its last value.
  - clr: same as accept, but the code is discarded (code_valid drops without a handshake).
- Display in ENTRY:
  - slot 0 = cur.
  - slots 1..count = confirmed digits, newest in slot 1.
  - slots above count = BLANK.
- Display in HOLD: slots 0..DIGITS-1 = confirmed digits, newest in slot 0.
- code is stable for the whole time code_valid is high.

## Timing
- All outputs are registered. An event sampled at edge n is visible after edge n.
- Final cnf at edge n: code_valid=1 and code are valid from n.
- code_ready=1 at edge m while code_valid=1: code_valid=0 after m, and the display returns to reset state. An up/down in the accept cycle is dropped.
- code_ready while code_valid=0 has no effect.
- Reset values: code_valid=0, code=0, count=0, state ENTRY, cur=0. disp: slot 0 = 0, all other slots BLANK.
- rst mid-entry or in HOLD drops everything immediately (asynchronous), including a pending code.

## Configuration
- CODE_ENTRY_MASK_EN defined: confirmed digits display as MASK in both ENTRY and HOLD. Slot 0 in ENTRY still shows cur. code is unaffected.
- CODE_ENTRY_MASK_EN undefined: confirmed digits display their real values.

## Test plan
- Reset, then 3× up, 1× down -> disp slot0=2, others BLANK (4'hF), count=0.
- down from 0 -> cur=9. Then up -> cur=0 (wrap both ways).
- Enter 1,2,3,4 with cnf after each (DIGITS=4):
  - code_valid=1 one cycle after the 4th cnf; code=16'h1234.
  - Hold code_ready=0 for 5 cycles: code stable, up/down ignored.
  - Pulse code_ready: code_valid=0 next cycle; count=0.
- Enter 5,6 confirmed, then back:
  - count=1, disp = {F,F,5,0}.
  - Then back twice: count=0, slot0=0.
- Simultaneous cnf+up with cur=3 -> digit 3 confirmed, cur=0. clr+back -> full clear. rst asserted in HOLD -> code_valid=0 immediately.
- With CODE_ENTRY_MASK_EN: after confirming 7,8 -> disp = {F,E,E,cur}; code contents unchanged.
